wide_add_seq: RTL

- Multi-precision add/subtract sequencer built around one instance of the team's 16-bit full adder.
- Computes a 16*WORDS-bit sum or difference by issuing one 16-bit word per cycle, LSW first, and chaining the carry in a register.
- Sits between the ALU issue logic and the shared adder. Produces the full-width result plus OV/ZF/NF/CF with a start/done handshake.

---
 rtl/wide_add_seq.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/wide_add_seq.sv
// Multi-precision add/subtract sequencer: one 16-bit word per cycle, LSW first,
// with the carry chained through a register and flags taken on the last word.

module add16 (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        cin,
   output logic [15:0] sum,
   output logic        cout
);
   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {16'd0, cin};
endmodule

module wide_add_seq #(
   parameter int WORDS = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                op_sub,
   input  logic [16*WORDS-1:0] a,
   input  logic [16*WORDS-1:0] b,
   output logic                ready,
   output logic                busy,
   output logic                done,
   output logic [16*WORDS-1:0] result,
   output logic                OV,
   output logic                ZF,
   output logic                NF,
   output logic                CF
);
   localparam int W  = 16 * WORDS;
   localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic          carry_q, carry_d;
   logic          zacc_q, zacc_d;
   logic [W-1:0]  a_q, a_d;
   logic [W-1:0]  b_q, b_d;
   logic [W-1:0]  result_q, result_d;
   logic          ov_q, ov_d;
   logic          zf_q, zf_d;
   logic          nf_q, nf_d;
   logic          cf_q, cf_d;

   logic [15:0]   add_a, add_b, add_sum;
   logic          add_cout;
   logic          last_word;

   assign add_a     = a_q[16*idx_q +: 16];
   assign add_b     = b_q[16*idx_q +: 16];
   assign last_word = (idx_q == IW'(WORDS - 1));

   add16 u_add16 (
      .a    (add_a),
      .b    (add_b),
      .cin  (carry_q),
      .sum  (add_sum),
      .cout (add_cout)
   );

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      carry_d  = carry_q;
      zacc_d   = zacc_q;
      a_d      = a_q;
      b_d      = b_q;
      result_d = result_q;
      ov_d     = ov_q;
      zf_d     = zf_q;
      nf_d     = nf_q;
      cf_d     = cf_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               // Subtract is A + ~B + 1: the +1 enters as the initial carry.
               a_d     = a;
               b_d     = op_sub ? ~b : b;
               carry_d = op_sub;
               idx_d   = '0;
               zacc_d  = 1'b1;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            result_d[16*idx_q +: 16] = add_sum;
            carry_d = add_cout;
            zacc_d  = zacc_q & (add_sum == 16'd0);
            if (last_word) begin
               cf_d    = add_cout;
               nf_d    = add_sum[15];
               zf_d    = zacc_q & (add_sum == 16'd0);
               ov_d    = (a_q[W-1] == b_q[W-1]) && (add_sum[15] != a_q[W-1]);
               state_d = ST_DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         idx_q    <= '0;
         carry_q  <= 1'b0;
         zacc_q   <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         ov_q     <= 1'b0;
         zf_q     <= 1'b0;
         nf_q     <= 1'b0;
         cf_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         carry_q  <= carry_d;
         zacc_q   <= zacc_d;
         a_q      <= a_d;
         b_q      <= b_d;
         result_q <= result_d;
         ov_q     <= ov_d;
         zf_q     <= zf_d;
         nf_q     <= nf_d;
         cf_q     <= cf_d;
      end
   end

   assign ready  = (state_q == ST_IDLE);
   assign busy   = (state_q == ST_RUN) || (state_q == ST_DONE);
   assign done   = (state_q == ST_DONE);
   assign result = result_q;
   assign OV     = ov_q;
   assign ZF     = zf_q;
   assign NF     = nf_q;
   assign CF     = cf_q;

endmodule
